// File: rtl/pixel_plane_split.sv
// Pixel splitter: unpacks RGB565/RGB888/GRAY8, expands each channel to
// CHANNEL_BITS and emits one BCM bit-plane per channel (R,G,B).
// Latency 2 clk (S1 = expanded channels, S2 = plane bits); 1 pixel/clk.
// Backpressure: S2 holds while out_valid & !out_ready; S1 holds behind it;
// in_ready = !s1_valid | s2_load (no path from in_valid).
//
// Ports:
//   clk, reset       - clock, async active-high reset
//   in_valid/ready   - input handshake; pixel, fmt, plane, dim_floor and
//                      rgb_enable are sampled together on the transfer
//   out_valid/ready  - output handshake for rgb_output ([0]=R,[1]=G,[2]=B)
//   plane_err        - sticky: accepted transfer had plane >= CHANNEL_BITS
//                      or fmt == 3; cleared only by reset
module pixel_plane_split #(
  parameter int CHANNEL_BITS = 8,
  parameter int PLANE_W      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [23:0]        pixel,
  input  logic [1:0]         fmt,
  input  logic [PLANE_W-1:0] plane,
  input  logic [PLANE_W-1:0] dim_floor,
  input  logic [2:0]         rgb_enable,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         rgb_output,
  output logic               plane_err
);

  localparam int C = CHANNEL_BITS;

  localparam logic [1:0] FMT_RGB565 = 2'd0;
  localparam logic [1:0] FMT_RGB888 = 2'd1;
  localparam logic [1:0] FMT_GRAY8  = 2'd2;

  // Left-align an s-bit source into C bits. Output bit C-1-i takes source
  // bit s-1-(i mod s): for s < C this replicates the source MSBs into the
  // low bits, for s >= C it simply keeps the top C bits.
  function automatic logic [C-1:0] expand(input logic [7:0] src, input int s);
    logic [C-1:0] res;
    res = '0;
    for (int i = 0; i < C; i++) begin
      res[C-1-i] = src[s-1-(i%s)];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic s1_valid;
  logic s2_load;
  logic in_xfer;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign in_xfer  = in_valid && in_ready;

  // ---------------------------------------------------------------------
  // Channel extraction and expansion (input side of S1)
  // ---------------------------------------------------------------------
  logic [C-1:0] r_in, g_in, b_in;
  logic         bad_in;

  always_comb begin
    r_in = '0;
    g_in = '0;
    b_in = '0;
    case (fmt)
      FMT_RGB565: begin
        r_in = expand({3'b000, pixel[15:11]}, 5);
        g_in = expand({2'b00,  pixel[10:5]},  6);
        b_in = expand({3'b000, pixel[4:0]},   5);
      end
      FMT_RGB888: begin
        r_in = expand(pixel[23:16], 8);
        g_in = expand(pixel[15:8],  8);
        b_in = expand(pixel[7:0],   8);
      end
      FMT_GRAY8: begin
        r_in = expand(pixel[7:0], 8);
        g_in = r_in;
        b_in = r_in;
      end
      default: begin
        // reserved format: channels stay zero
      end
    endcase
  end

  assign bad_in = (fmt == 2'd3) || (int'(plane) >= C);

  // ---------------------------------------------------------------------
  // S1: expanded channels plus sideband
  // ---------------------------------------------------------------------
  logic [C-1:0]       s1_r, s1_g, s1_b;
  logic [PLANE_W-1:0] s1_plane;
  logic [PLANE_W-1:0] s1_dim;
  logic [2:0]         s1_en;
  logic               s1_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_plane <= '0;
      s1_dim   <= '0;
      s1_en    <= '0;
      s1_bad   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_xfer) begin
        s1_r     <= r_in;
        s1_g     <= g_in;
        s1_b     <= b_in;
        s1_plane <= plane;
        s1_dim   <= dim_floor;
        s1_en    <= rgb_enable;
        s1_bad   <= bad_in;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Plane select (input side of S2)
  // ---------------------------------------------------------------------
  logic [C-1:0] r_sh, g_sh, b_sh;
  logic         plane_on;
  logic [2:0]   sel_bits;

  // Shifting right by the plane index puts the wanted bit at [0]; an
  // out-of-range index shifts to zero, and s1_bad masks it regardless.
  assign r_sh     = s1_r >> s1_plane;
  assign g_sh     = s1_g >> s1_plane;
  assign b_sh     = s1_b >> s1_plane;
  assign plane_on = !s1_bad && (s1_plane >= s1_dim);
  assign sel_bits = {b_sh[0], g_sh[0], r_sh[0]} & s1_en & {3{plane_on}};

  // ---------------------------------------------------------------------
  // S2: output register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      rgb_output <= 3'b000;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        rgb_output <= sel_bits;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sticky error flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      plane_err <= 1'b0;
    end else if (in_xfer && bad_in) begin
      plane_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_plane_split.sv
module tb_pixel_plane_split;

  localparam int CB = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [23:0]   pixel;
  logic [1:0]    fmt;
  logic [PW-1:0] plane;
  logic [PW-1:0] dim_floor;
  logic [2:0]    rgb_enable;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    rgb_output;
  logic          plane_err;

  pixel_plane_split #(.CHANNEL_BITS(CB), .PLANE_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pixel      (pixel),
    .fmt        (fmt),
    .plane      (plane),
    .dim_floor  (dim_floor),
    .rgb_enable (rgb_enable),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rgb_output (rgb_output),
    .plane_err  (plane_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         out_count = 0;
  logic [2:0] expq[$];
  logic       exp_err = 1'b0;
  logic       in_x, out_x, last_in_ready;
  logic       prev_stall = 1'b0;
  logic [2:0] prev_rgb = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: channel values by plain arithmetic (MSB replication as
  // shift-or), then pick the plane bit.
  function automatic logic [2:0] model(input logic [23:0] p, input logic [1:0] f,
                                       input logic [PW-1:0] pl, input logic [PW-1:0] dm,
                                       input logic [2:0] en);
    int r, g, b;
    case (f)
      2'd0: begin
        r = int'(p[15:11]); r = (r << 3) | (r >> 2);
        g = int'(p[10:5]);  g = (g << 2) | (g >> 4);
        b = int'(p[4:0]);   b = (b << 3) | (b >> 2);
      end
      2'd1: begin
        r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
      end
      2'd2: begin
        r = int'(p[7:0]); g = r; b = r;
      end
      default: return 3'b000;
    endcase
    if (int'(pl) >= CB || pl < dm) return 3'b000;
    return {((b >> pl) & 1) != 0, ((g >> pl) & 1) != 0, ((r >> pl) & 1) != 0} & en;
  endfunction

  // One clock: sample at negedge, score transfers, return #1 after posedge.
  task automatic cycle();
    @(negedge clk);
    last_in_ready = in_ready;
    in_x  = in_valid & in_ready;
    out_x = out_valid & out_ready;
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", rgb_output, prev_rgb);
    end
    if (out_x) begin
      if (expq.size() == 0) chk("no_stale_output", out_valid, 0);
      else begin
        chk("data", rgb_output, expq.pop_front());
        out_count++;
      end
    end
    if (in_x) begin
      expq.push_back(model(pixel, fmt, plane, dim_floor, rgb_enable));
      if (fmt == 2'd3 || int'(plane) >= CB) exp_err = 1'b1;
    end
    prev_stall = out_valid & ~out_ready;
    prev_rgb   = rgb_output;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] p, input logic [1:0] f, input logic [PW-1:0] pl,
                      input logic [PW-1:0] dm, input logic [2:0] en);
    int n;
    pixel = p; fmt = f; plane = pl; dim_floor = dm; rgb_enable = en;
    in_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!in_x && n < 100);
    if (!in_x) chk("send_timeout", in_x, 1);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while ((expq.size() != 0 || out_valid) && n < 200) begin
      cycle();
      n++;
    end
    chk("drain_empty", expq.size(), 0);
  endtask

  initial begin
    int idx, c0;
    reset = 1'b1; in_valid = 1'b0; pixel = '0; fmt = '0; plane = '0;
    dim_floor = '0; rgb_enable = '0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rgb", rgb_output, 0);
    chk("rst_plane_err", plane_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);

    // 1: RGB565 red, planes 0..7, latency of the first pixel
    send(24'h00F800, 2'd0, 4'd0, 4'd0, 3'b111);
    chk("latency_1clk", out_valid, 0);
    send(24'h00F800, 2'd0, 4'd1, 4'd0, 3'b111);
    chk("latency_2clk", out_valid, 1);
    for (int p = 2; p < 8; p++) send(24'h00F800, 2'd0, PW'(p), 4'd0, 3'b111);
    drain();

    // 2: RGB888
    send(24'h8001FF, 2'd1, 4'd7, 4'd0, 3'b111);
    send(24'h8001FF, 2'd1, 4'd0, 4'd0, 3'b111);
    send(24'h8001FF, 2'd1, 4'd0, 4'd0, 3'b010);
    drain();

    // 3: GRAY8 with dimming floor
    for (int p = 0; p < 8; p++) send(24'h00000F, 2'd2, PW'(p), 4'd2, 3'b111);
    drain();

    // 4: back-pressure mid-stream
    idx = 0;
    c0  = out_count;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (idx < 6);
      pixel = 24'($urandom); fmt = 2'($urandom_range(0, 2));
      plane = PW'($urandom_range(0, 7)); dim_floor = PW'($urandom_range(0, 3));
      rgb_enable = 3'($urandom);
      cycle();
      if (cyc >= 2 && cyc <= 4) chk("stall_in_ready", last_in_ready, 0);
      if (in_x) idx++;
    end
    out_ready = 1'b1;
    drain();
    chk("bp_out_count", out_count - c0, 6);

    // random legal traffic with random handshakes
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      pixel = 24'($urandom); fmt = 2'($urandom_range(0, 2));
      plane = PW'($urandom_range(0, 7)); dim_floor = PW'($urandom_range(0, 4));
      rgb_enable = 3'($urandom);
      cycle();
    end
    out_ready = 1'b1;
    drain();
    chk("plane_err_clean", plane_err, exp_err);

    // toggling out_ready every cycle
    for (int cyc = 0; cyc < 40; cyc++) begin
      in_valid = 1'b1; out_ready = cyc[0];
      pixel = 24'($urandom); fmt = 2'($urandom_range(0, 2));
      plane = PW'($urandom_range(0, 7)); dim_floor = '0; rgb_enable = 3'b111;
      cycle();
    end
    out_ready = 1'b1;
    drain();

    // 5: illegal plane and reserved format
    send(24'hFFFFFF, 2'd0, 4'd8, 4'd0, 3'b111);
    drain();
    chk("err_plane", plane_err, 1);
    send(24'hFFFFFF, 2'd3, 4'd3, 4'd0, 3'b111);
    drain();
    chk("err_fmt", plane_err, exp_err);
    send(24'h123456, 2'd1, 4'd2, 4'd0, 3'b111);
    drain();
    chk("err_sticky", plane_err, 1);

    // 6: reset with two pixels in flight
    out_ready = 1'b0;
    send(24'hFFFFFF, 2'd1, 4'd1, 4'd0, 3'b111);
    send(24'hFFFFFF, 2'd1, 4'd2, 4'd0, 3'b111);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_plane_err", plane_err, 0);
    chk("midrst_rgb", rgb_output, 0);
    expq.delete();
    exp_err = 1'b0;
    prev_stall = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    c0 = out_count;
    repeat (6) cycle();
    chk("no_output_after_rst", out_count - c0, 0);
    chk("post_rst_in_ready", in_ready, 1);
    send(24'h00FF00, 2'd1, 4'd4, 4'd0, 3'b111);
    drain();
    chk("post_rst_count", out_count - c0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_plane_split.md
Name: pixel_plane_split

Overview:
Parametrised successor to the RGB565 pixel splitter. It accepts one pixel per transfer in a runtime-selectable format (RGB565, RGB888, GRAY8) and expands each channel to CHANNEL_BITS. It then selects one binary-code-modulation bit-plane per channel, applying per-channel enables and a dimming floor. The block sits between the framebuffer read path and the row shifter, behind a 2-stage valid/ready pipeline.

Parameters:
CHANNEL_BITS, 8, per-channel expanded depth; legal range 4..8.
PLANE_W, 3, width of plane index; must satisfy 2**PLANE_W >= CHANNEL_BITS.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  pixel + sideband valid.
in_ready  out  1  block can accept the current transfer.
pixel  in  24  pixel word; RGB565 uses [15:0], GRAY8 uses [7:0], upper bits are ignored.
fmt  in  2  0=RGB565, 1=RGB888, 2=GRAY8, 3=reserved.
plane  in  PLANE_W  bit-plane index, 0 = LSB.
dim_floor  in  PLANE_W  planes below this index are forced to 0.
rgb_enable  in  3  per-channel enable; [0]=R, [1]=G, [2]=B.
out_valid  out  1  rgb_output valid.
out_ready  in  1  downstream accepts.
rgb_output  out  3  selected plane bit; [0]=R, [1]=G, [2]=B.
plane_err  out  1  sticky: a transfer was accepted with plane >= CHANNEL_BITS or fmt==3.

Behaviour:
- Reset (async, immediate): both stage valids=0, out_valid=0, rgb_output=0, plane_err=0, in_ready=1 on the first clk edge after release.
  - Reset mid-pipeline discards all in-flight pixels; no output is emitted for them.
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - All inputs (pixel, fmt, plane, dim_floor, rgb_enable) are sampled together on the input transfer.
- Pipeline:
  - S1 registers the expanded channels plus sideband.
  - S2 registers rgb_output.
  - Latency: 2 clk from input transfer to out_valid when unstalled.
  - Throughput: 1 pixel per clk.
- Stall logic:
  - S2 loads when !out_valid | out_ready.
  - S1 advances when S2 loads.
  - in_ready = !s1_valid | s2_load (combinational; no comb path from in_valid to in_ready).
- While out_valid=1 & out_ready=0: rgb_output and out_valid hold stable. Data is never dropped or duplicated.
- Channel extraction:
  - RGB565: R=[15:11], G=[10:5], B=[4:0].
  - RGB888: R=[23:16], G=[15:8], B=[7:0].
  - GRAY8: R=G=B=[7:0].
- Expansion to CHANNEL_BITS (C):
  - Source width s < C: left-align the source and fill the low C-s bits by repeating the source MSBs (bit replication). Examples: 5'b11111 -> 8'hFF, 5'b10000 -> 8'h84.
  - s >= C: keep the top C bits.
- Plane select, per channel c: out[c] = ch_c[plane] & rgb_enable[c] & (plane >= dim_floor).
- Illegal inputs:
  - plane >= C: all outputs 0 and plane_err set.
  - fmt==3: channels treated as 0 and plane_err set.
  - plane_err clears only on reset.
- Simultaneous events:
  - Input and output transfers in the same cycle with the pipeline full: pipeline shifts, no bubble.
  - out_ready toggling every cycle must not reorder pixels.

Test Plan:
1. RGB565 pixel 16'hF800, plane 0..7 sequentially, rgb_enable=3'b111, dim_floor=0, out_ready=1 -> rgb_output=3'b001 for all 8 planes; first out_valid 2 clk after first transfer.
2. RGB888 pixel 24'h80_01_FF, plane 7 -> 3'b101; plane 0 -> 3'b110; rgb_enable=3'b010 at plane 0 -> 3'b010.
3. GRAY8 pixel 8'h0F, dim_floor=2, planes 0..7 -> 000,000,111,111,000,000,000,000.
4. Back-pressure: stream 6 pixels with out_ready low for 3 cycles mid-stream -> in_ready drops after 2 held pixels, outputs remain in order and stable while stalled, exactly 6 output transfers.
5. plane=8 with CHANNEL_BITS=8 (PLANE_W=4 build) -> rgb_output=3'b000, plane_err=1 and stays set; fmt=3 -> same result.
6. Assert reset with 2 pixels in flight -> out_valid=0 and plane_err=0 immediately; no stale output after release.
